// File: rtl/ram_io_initiator.sv
// CPU-side initiator for the 4002 RAM bus: holds SRC/DCL selection, sequences
// chip select / write strobe for I/O-group ops, and returns read nibbles.
module ram_io_initiator #(
  parameter int NBANK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [3:0]            cmd_opa,
  input  logic [7:0]            cmd_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [3:0]            rsp_data,
  output logic [5:0]            ram_addr,
  output logic [3:0]            ram_opa,
  output logic [3:0]            ram_din,
  output logic                  ram_we,
  output logic [4*NBANK-1:0]    ram_cs,
  input  logic [16*NBANK-1:0]   ram_dout,
  output logic [7:0]            src_reg,
  output logic [2:0]            dcl_reg
);

  localparam int          NCHIP = 4 * NBANK;
  localparam int unsigned NB    = NBANK;

  localparam logic [1:0] CMD_IO  = 2'd0;
  localparam logic [1:0] CMD_SRC = 2'd1;
  localparam logic [1:0] CMD_DCL = 2'd2;

  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_WPM = 4'h3;
  localparam logic [3:0] OPA_RDR = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_STROBE,
    ST_CAPTURE,
    ST_RESP
  } state_t;

  state_t             state_q, state_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [3:0]         rsp_data_q, rsp_data_d;
  logic [5:0]         ram_addr_q, ram_addr_d;
  logic [3:0]         ram_opa_q, ram_opa_d;
  logic [3:0]         ram_din_q, ram_din_d;
  logic               ram_we_q, ram_we_d;
  logic [NCHIP-1:0]   ram_cs_q, ram_cs_d;
  logic [7:0]         src_q, src_d;
  logic [2:0]         dcl_q, dcl_d;

  logic [4:0]         chip_idx;
  logic               bank_ok;
  logic [NCHIP-1:0]   sel_onehot;
  logic [3:0]         rd_nibble;
  logic               opa_non_ram;

  // Selection only changes in IDLE, so it stays valid through CAPTURE.
  assign chip_idx = {dcl_q, src_q[7:6]};
  assign bank_ok  = (32'(dcl_q) < NB);

  genvar gi;
  generate
    for (gi = 0; gi < NCHIP; gi++) begin : g_sel
      assign sel_onehot[gi] = bank_ok && (chip_idx == 5'(gi));
    end
  endgenerate

  always_comb begin
    rd_nibble = 4'h0;
    for (int i = 0; i < NCHIP; i++) begin
      if (sel_onehot[i]) begin
        rd_nibble = rd_nibble | ram_dout[4*i +: 4];
      end
    end
  end

  assign opa_non_ram = (cmd_opa == OPA_WRR) || (cmd_opa == OPA_WPM) ||
                       (cmd_opa == OPA_RDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 4'h0;
      ram_addr_q  <= 6'h0;
      ram_opa_q   <= 4'h0;
      ram_din_q   <= 4'h0;
      ram_we_q    <= 1'b0;
      ram_cs_q    <= '0;
      src_q       <= 8'h0;
      dcl_q       <= 3'h0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_opa_q   <= ram_opa_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      ram_cs_q    <= ram_cs_d;
      src_q       <= src_d;
      dcl_q       <= dcl_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    ram_addr_d  = ram_addr_q;
    ram_opa_d   = ram_opa_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = ram_we_q;
    ram_cs_d    = ram_cs_q;
    src_d       = src_q;
    dcl_d       = dcl_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          case (cmd_type)
            CMD_SRC: src_d = cmd_data;
            CMD_DCL: dcl_d = cmd_data[2:0];
            CMD_IO: begin
              cmd_ready_d = 1'b0;
              if (opa_non_ram) begin
                rsp_data_d  = 4'h0;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
              end else begin
                ram_addr_d = src_q[5:0];
                ram_opa_d  = cmd_opa;
                ram_din_d  = cmd_data[3:0];
                ram_cs_d   = sel_onehot;
                state_d    = ST_ISSUE;
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE: begin
        // Among RAM opcodes, bit 3 clear means a write.
        if (!ram_opa_q[3]) begin
          ram_we_d = 1'b1;
          state_d  = ST_STROBE;
        end else begin
          ram_cs_d = '0;
          state_d  = ST_CAPTURE;
        end
      end
      ST_STROBE: begin
        ram_cs_d    = '0;
        ram_we_d    = 1'b0;
        rsp_data_d  = 4'h0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_CAPTURE: begin
        rsp_data_d  = rd_nibble;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_opa   = ram_opa_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign ram_cs    = ram_cs_q;
  assign src_reg   = src_q;
  assign dcl_reg   = dcl_q;

endmodule

// File: tb/tb_ram_io_initiator.sv
// Bench for ram_io_initiator: behavioural 4002 array model plus a response
// scoreboard; each task drives one scenario and checks it inline.
module tb_ram_io_initiator;

  localparam int NBANK = 4;
  localparam int NCHIP = 4 * NBANK;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [1:0]           cmd_type = 2'd3;
  logic [3:0]           cmd_opa = 4'h0;
  logic [7:0]           cmd_data = 8'h0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [3:0]           rsp_data;
  logic [5:0]           ram_addr;
  logic [3:0]           ram_opa;
  logic [3:0]           ram_din;
  logic                 ram_we;
  logic [NCHIP-1:0]     ram_cs;
  logic [16*NBANK-1:0]  ram_dout;
  logic [7:0]           src_reg;
  logic [2:0]           dcl_reg;

  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  ram_io_initiator #(.NBANK(NBANK)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_opa(cmd_opa), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_opa(ram_opa), .ram_din(ram_din),
    .ram_we(ram_we), .ram_cs(ram_cs), .ram_dout(ram_dout),
    .src_reg(src_reg), .dcl_reg(dcl_reg)
  );

  // RAM chip model: dout registered on a selected edge, write on cs & we.
  logic       model_clr = 1'b1;
  logic [3:0] mem [NCHIP][64];
  logic [3:0] dout_q [NCHIP];

  always @(posedge clk) begin
    for (int i = 0; i < NCHIP; i++) begin
      if (model_clr) begin
        dout_q[i] <= 4'h0;
        for (int a = 0; a < 64; a++) mem[i][a] <= 4'h0;
      end else if (ram_cs[i]) begin
        dout_q[i] <= mem[i][ram_addr];
        if (ram_we) mem[i][ram_addr] <= ram_din;
      end
    end
  end

  always_comb begin
    ram_dout = '0;
    for (int i = 0; i < NCHIP; i++) ram_dout[4*i +: 4] = dout_q[i];
  end

  always @(negedge clk) begin
    if (reset_n && !$onehot0(ram_cs)) begin
      errors++;
      $display("FAIL cs_onehot: ram_cs=%h has more than one bit set", ram_cs);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] t, input logic [3:0] o, input logic [7:0] d);
    cmd_type  = t;
    cmd_opa   = o;
    cmd_data  = d;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    cmd_type  = 2'd3;
  endtask

  // Called at T+1; returns the cycle (relative to accept edge) rsp_valid rose, or -1.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 12) begin
      step();
      lat++;
    end
    if (rsp_valid !== 1'b1) lat = -1;
  endtask

  task automatic pop_expect(output logic [3:0] e, output logic ok);
    ok = (sb.size() > 0);
    e  = ok ? sb.pop_front() : 4'hx;
  endtask

  task automatic test_reset();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_data !== 4'h0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
    checks++; if (ram_cs !== '0 || ram_we !== 1'b0) begin errors++; $display("FAIL reset_cs_we: cs=%h we=%b expected 0/0", ram_cs, ram_we); end
    checks++; if (ram_addr !== 6'h0 || ram_opa !== 4'h0 || ram_din !== 4'h0) begin errors++; $display("FAIL reset_bus: addr=%h opa=%h din=%h expected 0", ram_addr, ram_opa, ram_din); end
    checks++; if (src_reg !== 8'h0 || dcl_reg !== 3'h0) begin errors++; $display("FAIL reset_sel: src=%h dcl=%h expected 0/0", src_reg, dcl_reg); end
    $display("reset: cmd_ready=%b src=%h dcl=%h", cmd_ready, src_reg, dcl_reg);
  endtask

  task automatic test_write();
    logic [NCHIP-1:0] exp_cs;
    logic [7:0] src_v;
    logic [3:0] e;
    logic ok;
    src_v = 8'h5A;
    exp_cs = '0;
    exp_cs[1*4 + int'(src_v >> 6)] = 1'b1;
    send_cmd(2'd1, 4'h0, src_v);
    checks++; if (src_reg !== 8'h5A || cmd_ready !== 1'b1) begin errors++; $display("FAIL src_load: src=%h rdy=%b expected 5a/1", src_reg, cmd_ready); end
    send_cmd(2'd2, 4'h0, 8'h01);
    checks++; if (dcl_reg !== 3'd1) begin errors++; $display("FAIL dcl_load: got %h expected 1", dcl_reg); end
    sb.push_back(4'h0);
    send_cmd(2'd0, 4'h0, 8'h07);
    checks++; if (ram_cs !== exp_cs || ram_we !== 1'b0) begin errors++; $display("FAIL wrm_t1_cs_we: cs=%h we=%b expected %h/0", ram_cs, ram_we, exp_cs); end
    checks++; if (ram_addr !== 6'h1A || ram_opa !== 4'h0 || ram_din !== 4'h7) begin errors++; $display("FAIL wrm_t1_bus: addr=%h opa=%h din=%h expected 1a/0/7", ram_addr, ram_opa, ram_din); end
    checks++; if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wrm_t1_hs: rdy=%b vld=%b expected 0/0", cmd_ready, rsp_valid); end
    step();
    checks++; if (ram_cs !== exp_cs || ram_we !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wrm_t2: cs=%h we=%b vld=%b expected %h/1/0", ram_cs, ram_we, rsp_valid, exp_cs); end
    step();
    checks++; if (ram_cs !== '0 || ram_we !== 1'b0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL wrm_t3: cs=%h we=%b vld=%b expected 0/0/1", ram_cs, ram_we, rsp_valid); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL wrm_rsp_data: got %h expected %h", rsp_data, e); end
    $display("WRM chip-sel=%h rsp=%h", exp_cs, rsp_data);
    step();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wrm_t4: vld=%b rdy=%b expected 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_read();
    logic [NCHIP-1:0] exp_cs;
    logic [3:0] e;
    logic ok;
    exp_cs = '0;
    exp_cs[5] = 1'b1;
    sb.push_back(4'h7);
    send_cmd(2'd0, 4'h9, 8'h00);
    checks++; if (ram_cs !== exp_cs || ram_we !== 1'b0 || ram_opa !== 4'h9) begin errors++; $display("FAIL rdm_t1: cs=%h we=%b opa=%h expected %h/0/9", ram_cs, ram_we, ram_opa, exp_cs); end
    step();
    checks++; if (ram_cs !== '0 || ram_we !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rdm_t2: cs=%h we=%b vld=%b expected 0/0/0", ram_cs, ram_we, rsp_valid); end
    step();
    checks++; if (rsp_valid !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL rdm_t3: vld=%b we=%b expected 1/0", rsp_valid, ram_we); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL rdm_rsp_data: got %h expected %h", rsp_data, e); end
    $display("RDM rsp=%h", rsp_data);
    step();
  endtask

  task automatic test_wr2_rd2();
    logic [3:0] e;
    logic ok;
    int lat;
    send_cmd(2'd1, 4'h0, 8'h30);
    send_cmd(2'd2, 4'h0, 8'h00);
    sb.push_back(4'h0);
    send_cmd(2'd0, 4'h6, 8'h0C);
    checks++; if (ram_cs !== NCHIP'(1) || ram_opa !== 4'h6 || ram_addr !== 6'h30) begin errors++; $display("FAIL wr2_t1: cs=%h opa=%h addr=%h expected 0001/6/30", ram_cs, ram_opa, ram_addr); end
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL wr2_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL wr2_rsp_data: got %h expected %h", rsp_data, e); end
    $display("WR2 rsp=%h", rsp_data);
    step();
    sb.push_back(4'hC);
    send_cmd(2'd0, 4'hE, 8'h00);
    checks++; if (ram_cs !== NCHIP'(1) || ram_opa !== 4'hE || ram_addr !== 6'h30) begin errors++; $display("FAIL rd2_t1: cs=%h opa=%h addr=%h expected 0001/e/30", ram_cs, ram_opa, ram_addr); end
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL rd2_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL rd2_rsp_data: got %h expected %h", rsp_data, e); end
    $display("RD2 rsp=%h", rsp_data);
    step();
  endtask

  task automatic test_backpressure();
    logic [3:0] e;
    logic ok;
    int lat;
    send_cmd(2'd1, 4'h0, 8'h5A);
    send_cmd(2'd2, 4'h0, 8'h01);
    rsp_ready = 1'b0;
    sb.push_back(4'h7);
    send_cmd(2'd0, 4'h9, 8'h00);
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== e || cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_%0d: vld=%b data=%h rdy=%b expected 1/%h/0", i, rsp_valid, rsp_data, cmd_ready, e); end
      cmd_type  = 2'd1;
      cmd_data  = 8'hFF;
      cmd_valid = 1'b1;
      step();
    end
    cmd_valid = 1'b0;
    cmd_type  = 2'd3;
    checks++; if (!ok || src_reg !== 8'h5A || rsp_data !== e) begin errors++; $display("FAIL bp_no_accept: src=%h data=%h expected 5a/%h", src_reg, rsp_data, e); end
    $display("RDM backpressured rsp=%h", rsp_data);
    rsp_ready = 1'b1;
    step();
    checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release: vld=%b rdy=%b expected 0/1", rsp_valid, cmd_ready); end
  endtask

  task automatic test_non_ram();
    logic [3:0] e;
    logic ok;
    int lat;
    sb.push_back(4'h0);
    send_cmd(2'd0, 4'hA, 8'h05);
    checks++; if (ram_cs !== '0 || ram_we !== 1'b0) begin errors++; $display("FAIL rdr_cs: cs=%h we=%b expected 0/0", ram_cs, ram_we); end
    wait_rsp(lat);
    checks++; if (lat != 1) begin errors++; $display("FAIL rdr_latency: got %0d expected 1", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL rdr_rsp_data: got %h expected %h", rsp_data, e); end
    $display("RDR rsp=%h", rsp_data);
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rdr_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_out_of_range();
    logic [3:0] e;
    logic ok;
    int lat;
    send_cmd(2'd1, 4'h0, 8'h00);
    send_cmd(2'd2, 4'h0, 8'h07);
    sb.push_back(4'h0);
    send_cmd(2'd0, 4'h0, 8'h03);
    checks++; if (ram_cs !== '0) begin errors++; $display("FAIL oor_wr_cs: got %h expected 0", ram_cs); end
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL oor_wr_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL oor_wr_data: got %h expected %h", rsp_data, e); end
    $display("WRM bank7 rsp=%h", rsp_data);
    step();
    // Bank 4 is the first out-of-range one; chip 28/16 would alias if not guarded.
    send_cmd(2'd2, 4'h0, 8'h04);
    sb.push_back(4'h0);
    send_cmd(2'd0, 4'h9, 8'h00);
    checks++; if (ram_cs !== '0) begin errors++; $display("FAIL oor_rd_cs: got %h expected 0", ram_cs); end
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL oor_rd_data: got %h expected %h", rsp_data, e); end
    $display("RDM bank4 rsp=%h", rsp_data);
    step();
  endtask

  task automatic test_reset_mid_op();
    logic [3:0] e;
    logic ok;
    int lat;
    send_cmd(2'd1, 4'h0, 8'h5A);
    send_cmd(2'd2, 4'h0, 8'h01);
    send_cmd(2'd0, 4'h0, 8'h09);
    step();
    checks++; if (ram_we !== 1'b1 || ram_cs === '0) begin errors++; $display("FAIL rst_strobe: we=%b cs=%h expected 1/nonzero", ram_we, ram_cs); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ram_cs !== '0 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_async_cs_we: cs=%h we=%b expected 0/0", ram_cs, ram_we); end
    checks++; if (src_reg !== 8'h0 || dcl_reg !== 3'h0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_state: src=%h dcl=%h vld=%b rdy=%b expected 0/0/0/1", src_reg, dcl_reg, rsp_valid, cmd_ready); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_no_rsp_%0d: vld=%b rdy=%b expected 0/1", i, rsp_valid, cmd_ready); end
      step();
    end
    $display("reset mid-STROBE: aborted write of 9");
    // The aborted write must not have reached chip 5; it still holds 7.
    send_cmd(2'd1, 4'h0, 8'h5A);
    send_cmd(2'd2, 4'h0, 8'h01);
    sb.push_back(4'h7);
    send_cmd(2'd0, 4'h9, 8'h00);
    wait_rsp(lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL rst_readback_latency: got %0d expected 3", lat); end
    pop_expect(e, ok);
    checks++; if (!ok || rsp_data !== e) begin errors++; $display("FAIL rst_readback_data: got %h expected %h", rsp_data, e); end
    $display("RDM after abort rsp=%h", rsp_data);
    step();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drained: %0d entries left, expected 0", sb.size()); end
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    model_clr = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    test_reset();
    test_write();
    test_read();
    test_wr2_rd2();
    test_backpressure();
    test_non_ram();
    test_out_of_range();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
